// File: rtl/branch_flag_unit.sv
// rtl/branch_flag_unit.sv - branch resolution, flag register and fetch PC sequencing
// Taken branches redirect pc and hold flush high for FLUSH_CYCLES unstalled cycles.
module branch_flag_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic        flag_we,
  input  logic        alu_zflag,
  input  logic        alu_carryflag,
  input  logic        alu_signflag,
  input  logic        alu_overflowflag,
  input  logic        pc_stall,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [3:0]  br_type,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_offset,
  input  logic [31:0] rs_value,
  output logic [31:0] pc,
  output logic        flush,
  output logic        link_we,
  output logic [31:0] link_value,
  output logic [3:0]  flags,
  output logic        misalign_err
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [2:0]  count;
  logic        flag_load;
  logic [3:0]  eff_flags;
  logic [31:0] rel_target;
  logic [31:0] target;
  logic        taken;
  logic        accept;
  logic        is_bl;
  logic        misaligned;

  assign br_ready = (state == RUN) && !pc_stall;

  // Conditions see the flags being written this edge, not the stale register.
  always_comb begin
    flag_load  = alu_valid && flag_we;
    eff_flags  = flag_load ? {alu_zflag, alu_carryflag, alu_signflag, alu_overflowflag} : flags;
    rel_target = br_pc + (br_offset << 2);
    target     = (br_type == 4'b0001) ? rs_value : rel_target;
    accept     = br_valid && br_ready;
    is_bl      = (br_type == 4'b0101);
    misaligned = (target[1:0] != 2'b00);
    taken      = 1'b0;
    case (br_type)
      4'b0000: taken = 1'b1;
      4'b0001: taken = 1'b1;
      4'b0010: taken = rs_value[31];
      4'b0011: taken = (rs_value == 32'd0);
      4'b0100: taken = (rs_value != 32'd0);
      4'b0101: taken = 1'b1;
      4'b0110: taken = eff_flags[2];
      4'b0111: taken = !eff_flags[2];
      4'b1000: taken = eff_flags[1];
      4'b1001: taken = !eff_flags[1];
      4'b1010: taken = eff_flags[0];
      4'b1011: taken = !eff_flags[0];
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      count        <= 3'd0;
      pc           <= RESET_PC;
      flush        <= 1'b0;
      flags        <= 4'b0000;
      link_we      <= 1'b0;
      link_value   <= 32'd0;
      misalign_err <= 1'b0;
    end else begin
      if (flag_load)
        flags <= eff_flags;
      link_we      <= accept && is_bl;
      misalign_err <= accept && taken && misaligned;
      if (accept && is_bl)
        link_value <= br_pc + 32'd4;
      if (!pc_stall) begin
        case (state)
          RUN: begin
            if (accept && taken && !misaligned) begin
              pc    <= target;
              state <= FLUSH;
              flush <= 1'b1;
              count <= FLUSH_LAST;
            end else begin
              pc <= pc + 32'd4;
            end
          end
          FLUSH: begin
            pc <= pc + 32'd4;
            if (count == 3'd0) begin
              state <= RUN;
              flush <= 1'b0;
            end else begin
              count <= count - 3'd1;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_flag_unit.sv
// tb/tb_branch_flag_unit.sv - table-driven scoreboard bench for branch_flag_unit
module tb_branch_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, flag_we;
  logic        alu_zflag, alu_carryflag, alu_signflag, alu_overflowflag;
  logic        pc_stall, br_valid, br_ready;
  logic [3:0]  br_type;
  logic [31:0] br_pc, br_offset, rs_value;
  logic [31:0] pc;
  logic        flush, link_we;
  logic [31:0] link_value;
  logic [3:0]  flags;
  logic        misalign_err;

  branch_flag_unit dut (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .flag_we(flag_we),
    .alu_zflag(alu_zflag), .alu_carryflag(alu_carryflag), .alu_signflag(alu_signflag),
    .alu_overflowflag(alu_overflowflag), .pc_stall(pc_stall), .br_valid(br_valid),
    .br_ready(br_ready), .br_type(br_type), .br_pc(br_pc), .br_offset(br_offset),
    .rs_value(rs_value), .pc(pc), .flush(flush), .link_we(link_we),
    .link_value(link_value), .flags(flags), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  t;
    logic [31:0] bpc, off, rs;
    logic        av, fwe;
    logic [3:0]  f;
    logic        stall;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic        flush, ready, link_we, mis;
    logic [31:0] link_value;
    logic [3:0]  flags;
  } exp_t;

  typedef struct {
    logic [3:0]  t;
    logic [31:0] bpc, off, rs;
    logic        fwe;
    logic [3:0]  f;
    logic        tk;
    logic [31:0] tgt;
    logic        mis, lnk;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[18];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] m_pc;
  logic [3:0]  m_flags;
  logic [31:0] m_link;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  function automatic stim_t idle(input logic stall);
    stim_t s;
    s = '{1'b0, 4'h0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'h0, stall};
    return s;
  endfunction

  function automatic stim_t from_vec(input vec_t x);
    stim_t s;
    s = '{1'b1, x.t, x.bpc, x.off, x.rs, x.fwe, x.fwe, x.f, 1'b0};
    return s;
  endfunction

  // Drive one cycle, push the expected post-edge state, compare after the edge.
  task automatic step(input stim_t s, input logic redir, input logic [31:0] tgt,
                      input logic mis, input logic lnk, input logic fl);
    exp_t e, g;
    br_valid = s.v; br_type = s.t; br_pc = s.bpc; br_offset = s.off; rs_value = s.rs;
    alu_valid = s.av; flag_we = s.fwe; pc_stall = s.stall;
    {alu_zflag, alu_carryflag, alu_signflag, alu_overflowflag} = s.f;
    e.pc = s.stall ? m_pc : (redir ? tgt : m_pc + 32'd4);
    if (s.av && s.fwe) m_flags = s.f;
    if (lnk) m_link = s.bpc + 32'd4;
    e.flags = m_flags; e.link_we = lnk; e.link_value = m_link;
    e.mis = mis; e.flush = fl; e.ready = !fl && !s.stall;
    sb.push_back(e);
    m_pc = e.pc;
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("pc", pc, g.pc);
    chk("flush", 32'(flush), 32'(g.flush));
    chk("br_ready", 32'(br_ready), 32'(g.ready));
    chk("flags", 32'(flags), 32'(g.flags));
    chk("link_we", 32'(link_we), 32'(g.link_we));
    chk("link_value", link_value, g.link_value);
    chk("misalign_err", 32'(misalign_err), 32'(g.mis));
  endtask

  task automatic drain_flush();
    for (int k = 0; k < 2; k++) step(idle(1'b0), 1'b0, 32'd0, 1'b0, 1'b0, k < 1);
  endtask

  initial begin
    vecs[0]  = '{4'h6, 32'h100,       32'd3,         32'd0,         1'b1, 4'b0100, 1'b1, 32'h10C, 1'b0, 1'b0};
    vecs[1]  = '{4'h5, 32'h40,        32'hFFFF_FFFC, 32'd0,         1'b0, 4'b0000, 1'b1, 32'h30,  1'b0, 1'b1};
    vecs[2]  = '{4'h1, 32'h0,         32'd0,         32'h202,       1'b0, 4'b0000, 1'b1, 32'h202, 1'b1, 1'b0};
    vecs[3]  = '{4'h4, 32'h80,        32'd4,         32'd0,         1'b0, 4'b0000, 1'b0, 32'h90,  1'b0, 1'b0};
    vecs[4]  = '{4'h3, 32'h200,       32'd1,         32'd0,         1'b0, 4'b0000, 1'b1, 32'h204, 1'b0, 1'b0};
    vecs[5]  = '{4'h2, 32'h1000,      32'h10,        32'h8000_0000, 1'b0, 4'b0000, 1'b1, 32'h1040,1'b0, 1'b0};
    vecs[6]  = '{4'h7, 32'h100,       32'd1,         32'd0,         1'b0, 4'b0000, 1'b0, 32'h104, 1'b0, 1'b0};
    vecs[7]  = '{4'h8, 32'h300,       32'd2,         32'd0,         1'b1, 4'b0010, 1'b1, 32'h308, 1'b0, 1'b0};
    vecs[8]  = '{4'h6, 32'h100,       32'd1,         32'd0,         1'b0, 4'b0000, 1'b0, 32'h104, 1'b0, 1'b0};
    vecs[9]  = '{4'hA, 32'h400,       32'd0,         32'd0,         1'b1, 4'b0001, 1'b1, 32'h400, 1'b0, 1'b0};
    vecs[10] = '{4'hB, 32'h100,       32'd1,         32'd0,         1'b0, 4'b0000, 1'b0, 32'h104, 1'b0, 1'b0};
    vecs[11] = '{4'hC, 32'h0,         32'd0,         32'd0,         1'b0, 4'b0000, 1'b0, 32'h0,   1'b0, 1'b0};
    vecs[12] = '{4'h0, 32'hFFFF_FFF0, 32'd8,         32'd0,         1'b0, 4'b0000, 1'b1, 32'h10,  1'b0, 1'b0};
    vecs[13] = '{4'h5, 32'h42,        32'd1,         32'd0,         1'b0, 4'b0000, 1'b1, 32'h46,  1'b1, 1'b1};
    vecs[14] = '{4'h9, 32'h500,       32'hFFFF_FFFF, 32'd0,         1'b0, 4'b0000, 1'b1, 32'h4FC, 1'b0, 1'b0};
    vecs[15] = '{4'h4, 32'h600,       32'd4,         32'd5,         1'b1, 4'b1000, 1'b1, 32'h610, 1'b0, 1'b0};
    vecs[16] = '{4'h7, 32'h100,       32'd1,         32'd0,         1'b1, 4'b0100, 1'b0, 32'h104, 1'b0, 1'b0};
    vecs[17] = '{4'hF, 32'h0,         32'd1,         32'd0,         1'b0, 4'b0000, 1'b0, 32'h4,   1'b0, 1'b0};

    rst_n = 1'b0;
    br_valid = 0; br_type = 0; br_pc = 0; br_offset = 0; rs_value = 0;
    alu_valid = 0; flag_we = 0; pc_stall = 0;
    {alu_zflag, alu_carryflag, alu_signflag, alu_overflowflag} = 4'h0;
    m_pc = 32'h0; m_flags = 4'h0; m_link = 32'h0;
    #1;
    chk("reset pc", pc, 32'h0);
    chk("reset flush", 32'(flush), 32'd0);
    chk("reset flags", 32'(flags), 32'd0);
    chk("reset misalign_err", 32'(misalign_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("pc after release", pc, 32'h0);
    for (int i = 0; i < 3; i++) step(idle(1'b0), 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      step(from_vec(vecs[i]), vecs[i].tk && !vecs[i].mis, vecs[i].tgt,
           vecs[i].tk && vecs[i].mis, vecs[i].lnk, vecs[i].tk && !vecs[i].mis);
      if (vecs[i].tk && !vecs[i].mis) drain_flush();
    end

    // Stall in RUN: branch ignored, flags still load; then alu_valid low blocks a load.
    step('{1'b1, 4'h0, 32'h700, 32'd0, 32'd0, 1'b1, 1'b1, 4'b0011, 1'b1}, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    step('{1'b0, 4'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1, 4'b1111, 1'b0}, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Stall for three cycles inside FLUSH.
    step('{1'b1, 4'h0, 32'h800, 32'd0, 32'd0, 1'b0, 1'b0, 4'h0, 1'b0}, 1'b1, 32'h800, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(idle(1'b1), 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    drain_flush();

    // Asynchronous reset while flushing.
    step('{1'b1, 4'h0, 32'h900, 32'd0, 32'd0, 1'b0, 1'b0, 4'h0, 1'b0}, 1'b1, 32'h900, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midflush reset pc", pc, 32'h0);
    chk("midflush reset flush", 32'(flush), 32'd0);
    chk("midflush reset flags", 32'(flags), 32'd0);
    chk("midflush reset link_value", link_value, 32'd0);
    chk("midflush reset link_we", 32'(link_we), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_pc = 32'h0; m_flags = 4'h0; m_link = 32'h0;
    step(idle(1'b0), 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    step(idle(1'b0), 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
